// File: rtl/imem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// imem_ctrl_pkg
// Shared types and constants for the instruction-memory fetch controller:
// FSM state encoding, address/byte/word geometry and the word-base helper.
// ---------------------------------------------------------------------------
package imem_ctrl_pkg;

  localparam int ADDR_W     = 6;
  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = BYTE_W * WORD_BYTES;
  localparam int TAG_W      = ADDR_W - 2;

  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Clears the byte-lane bits so the result is the word-aligned base.
  function automatic logic [ADDR_W-1:0] word_base(input logic [ADDR_W-1:0] addr);
    return addr & ~LANE_MASK;
  endfunction

endpackage

// File: rtl/imem_word_buf.sv
// ---------------------------------------------------------------------------
// imem_word_buf
// One-entry buffer holding the most recently fetched instruction word.
// Only instantiated when IMEM_FETCH_HIT_EN is defined.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears valid)
//   lookup_tag          word tag of the fetch being arbitrated
//   hit, hit_data       tag match with a valid entry, and the stored word
//   fill, fill_tag,
//   fill_data           write a freshly assembled word (completed miss)
//   inval, inval_tag    a byte write to inval_tag drops the entry on match
// ---------------------------------------------------------------------------
module imem_word_buf
  import imem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [WORD_W-1:0] hit_data,
  input  logic              fill,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [WORD_W-1:0] fill_data,
  input  logic              inval,
  input  logic [TAG_W-1:0]  inval_tag
);

  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [WORD_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill) begin
      valid_d = 1'b1;
      tag_d   = fill_tag;
      data_d  = fill_data;
    end else if (inval && (inval_tag == tag_q)) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign hit      = valid_q && (tag_q == lookup_tag);
  assign hit_data = data_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
// Arbitrates between CPU instruction fetches (32-bit words assembled from
// four byte reads, little-endian) and program-loader byte writes onto a
// single byte-wide memory port. Ties in IDLE are resolved round-robin.
//
// Optional feature: define IMEM_FETCH_HIT_EN to add a one-entry word buffer
// (imem_word_buf) that answers repeat fetches without memory reads.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   fetch_req, fetch_addr          fetch request (held until fetch_valid)
//   fetch_valid, fetch_data        one-cycle response pulse and word
//   load_req, load_addr, load_data loader byte write (held until load_ack)
//   load_ack                       pulse in the cycle the write is driven
//   busy                           controller not in IDLE
//   mem_read_rq, mem_write_rq,
//   mem_addr, mem_wdata, mem_rdata byte memory port (async read, sync write)
// ---------------------------------------------------------------------------
module imem_fetch_ctrl
  import imem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [WORD_W-1:0] fetch_data,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [BYTE_W-1:0] load_data,
  output logic              load_ack,
  output logic              busy,
  output logic              mem_read_rq,
  output logic              mem_write_rq,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  input  logic [BYTE_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rr_load_last_q, rr_load_last_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [BYTE_W-1:0] ld_data_q, ld_data_d;
  logic [WORD_W-BYTE_W-1:0] asm_q, asm_d;
  logic              grant_fetch, grant_load;

`ifdef IMEM_FETCH_HIT_EN
  logic              buf_hit;
  logic [WORD_W-1:0] buf_data;
  logic              buf_fill, buf_inval;

  imem_word_buf u_word_buf (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (fetch_addr[ADDR_W-1:2]),
    .hit        (buf_hit),
    .hit_data   (buf_data),
    .fill       (buf_fill),
    .fill_tag   (base_q[ADDR_W-1:2]),
    .fill_data  (data_d),
    .inval      (buf_inval),
    .inval_tag  (ld_addr_q[ADDR_W-1:2])
  );
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rr_load_last_d = rr_load_last_q;
    data_d         = data_q;
    base_d         = base_q;
    ld_addr_d      = ld_addr_q;
    ld_data_d      = ld_data_q;
    asm_d          = asm_q;
    grant_fetch    = 1'b0;
    grant_load     = 1'b0;
    fetch_valid    = 1'b0;
    load_ack       = 1'b0;
    mem_read_rq    = 1'b0;
    mem_write_rq   = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
`ifdef IMEM_FETCH_HIT_EN
    buf_fill       = 1'b0;
    buf_inval      = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // On a tie the fetch wins only if the loader was granted last.
        grant_fetch = fetch_req && (!load_req || rr_load_last_q);
        grant_load  = load_req && !grant_fetch;
        if (grant_fetch) begin
          base_d         = word_base(fetch_addr);
          cnt_d          = '0;
          rr_load_last_d = 1'b0;
`ifdef IMEM_FETCH_HIT_EN
          if (buf_hit) begin
            data_d  = buf_data;
            state_d = ST_RESP;
          end else begin
            state_d = ST_RD;
          end
`else
          state_d = ST_RD;
`endif
        end else if (grant_load) begin
          ld_addr_d      = load_addr;
          ld_data_d      = load_data;
          rr_load_last_d = 1'b1;
          state_d        = ST_WR;
        end
      end

      ST_RD: begin
        mem_read_rq = 1'b1;
        mem_addr    = base_q + ADDR_W'(cnt_q);
        cnt_d       = cnt_q + 2'd1;
        // Lanes 0..2 collect in asm_q; the output word only changes when the
        // last byte arrives so fetch_data holds its old value until RESP.
        case (cnt_q)
          2'd0: asm_d[7:0]   = mem_rdata;
          2'd1: asm_d[15:8]  = mem_rdata;
          2'd2: asm_d[23:16] = mem_rdata;
          default: begin
            data_d  = {mem_rdata, asm_q};
            state_d = ST_RESP;
`ifdef IMEM_FETCH_HIT_EN
            buf_fill = 1'b1;
`endif
          end
        endcase
      end

      ST_WR: begin
        mem_write_rq = 1'b1;
        mem_addr     = ld_addr_q;
        mem_wdata    = ld_data_q;
        load_ack     = 1'b1;
        state_d      = ST_IDLE;
`ifdef IMEM_FETCH_HIT_EN
        buf_inval    = 1'b1;
`endif
      end

      ST_RESP: begin
        fetch_valid = 1'b1;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      rr_load_last_q <= 1'b0;
      data_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rr_load_last_q <= rr_load_last_d;
      data_q         <= data_d;
    end
  end

  // Operand latches are only consumed in states reachable after a grant.
  always_ff @(posedge clk) begin
    base_q    <= base_d;
    ld_addr_q <= ld_addr_d;
    ld_data_q <= ld_data_d;
    asm_q     <= asm_d;
  end

  assign busy       = (state_q != ST_IDLE);
  assign fetch_data = data_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Randomized scoreboard bench for imem_fetch_ctrl. A byte-array memory model
// sits on the memory port; a reference model (byte array plus optional
// one-word buffer state) predicts every response, which is queued and then
// compared by an independent monitor. Honors IMEM_FETCH_HIT_EN.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;
  import imem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [5:0]  fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        load_req;
  logic [5:0]  load_addr;
  logic [7:0]  load_data;
  logic        load_ack;
  logic        busy;
  logic        mem_read_rq;
  logic        mem_write_rq;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_valid  (fetch_valid),
    .fetch_data   (fetch_data),
    .load_req     (load_req),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .load_ack     (load_ack),
    .busy         (busy),
    .mem_read_rq  (mem_read_rq),
    .mem_write_rq (mem_write_rq),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Byte memory attached to the DUT: async read, write at the edge.
  logic [7:0] mem [64];
  logic [7:0] init_mem [64];
  logic       mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
    end else if (mem_write_rq) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  // Reference model state.
  logic [7:0] ref_mem [64];
  bit         bv;
  logic [3:0] bt;

  typedef struct {
    bit          is_fetch;
    logic [5:0]  base;
    logic [31:0] data;
    logic [5:0]  waddr;
    logic [7:0]  wdata;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int          rd_cnt = 0;
  logic [31:0] last_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_fetch(input logic [5:0] a);
    exp_t e;
    logic [5:0] b;
    b = {a[5:2], 2'b00};
    e.is_fetch = 1'b1;
    e.base     = b;
    e.waddr    = '0;
    e.wdata    = '0;
    e.data     = {ref_mem[b + 6'd3], ref_mem[b + 6'd2], ref_mem[b + 6'd1], ref_mem[b]};
`ifdef IMEM_FETCH_HIT_EN
    e.lat = (bv && bt == b[5:2]) ? 1 : 5;
`else
    e.lat = 5;
`endif
    bv = 1'b1;
    bt = b[5:2];
    return e;
  endfunction

  function automatic exp_t model_load(input logic [5:0] a, input logic [7:0] d);
    exp_t e;
    e.is_fetch = 1'b0;
    e.base     = '0;
    e.data     = '0;
    e.waddr    = a;
    e.wdata    = d;
    e.lat      = 1;
    ref_mem[a] = d;
    if (bt == a[5:2]) bv = 1'b0;
    return e;
  endfunction

  // Monitor: samples on the falling edge, pops the scoreboard on responses.
  always @(negedge clk) begin
    if (!rst && !mem_init) begin
      check("rq_exclusive", 32'(mem_read_rq & mem_write_rq), 32'h0);
      if (!busy) check("idle_strobes", {30'h0, mem_read_rq, mem_write_rq}, 32'h0);
      if (mem_read_rq) begin
        if (sbq.size() == 0 || !sbq[0].is_fetch) check("unexpected_read", 32'h1, 32'h0);
        else check("rd_addr", 32'(mem_addr), 32'(sbq[0].base) + 32'(rd_cnt));
        rd_cnt++;
      end
      if (fetch_valid) begin
        if (sbq.size() == 0 || !sbq[0].is_fetch) begin
          check("unexpected_fetch_valid", 32'h1, 32'h0);
        end else begin
          check("fetch_data", fetch_data, sbq[0].data);
          check("fetch_read_count", 32'(rd_cnt), (sbq[0].lat == 1) ? 32'd0 : 32'd4);
          last_data = sbq[0].data;
          void'(sbq.pop_front());
        end
        rd_cnt = 0;
      end else begin
        check("fetch_data_hold", fetch_data, last_data);
      end
      if (load_ack) begin
        if (sbq.size() == 0 || sbq[0].is_fetch) begin
          check("unexpected_load_ack", 32'h1, 32'h0);
        end else begin
          check("wr_strobe", 32'(mem_write_rq), 32'h1);
          check("wr_addr", 32'(mem_addr), 32'(sbq[0].waddr));
          check("wr_data", 32'(mem_wdata), 32'(sbq[0].wdata));
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_fetch_valid"}, 32'(fetch_valid), 32'h0);
    check({tag, "_load_ack"}, 32'(load_ack), 32'h0);
    check({tag, "_strobes"}, {30'h0, mem_read_rq, mem_write_rq}, 32'h0);
    check({tag, "_fetch_data"}, fetch_data, 32'h0);
  endtask

  task automatic model_reset();
    sbq.delete();
    bv        = 1'b0;
    rd_cnt    = 0;
    last_data = 32'h0;
  endtask

  task automatic do_fetch(input logic [5:0] a);
    exp_t e;
    bit   done;
    e = model_fetch(a);
    sbq.push_back(e);
    fetch_addr = a;
    fetch_req  = 1'b1;
    done = 1'b0;
    for (int n = 1; n <= 30 && !done; n++) begin
      tick();
      if (fetch_valid) begin
        check("fetch_latency", 32'(n), 32'(e.lat));
        done = 1'b1;
      end
    end
    if (!done) check("fetch_timeout", 32'h0, 32'h1);
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic do_load(input logic [5:0] a, input logic [7:0] d);
    exp_t e;
    bit   done;
    e = model_load(a, d);
    sbq.push_back(e);
    load_addr = a;
    load_data = d;
    load_req  = 1'b1;
    done = 1'b0;
    for (int n = 1; n <= 30 && !done; n++) begin
      tick();
      if (load_ack) begin
        check("load_latency", 32'(n), 32'h1);
        done = 1'b1;
      end
    end
    if (!done) check("load_timeout", 32'h0, 32'h1);
    load_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fa [2];
    logic [5:0] la [2];
    logic [7:0] ld [2];
    int  fi, li, idle;
    bit  found;

    for (int i = 0; i < 64; i++) init_mem[i] = 8'($urandom);
    init_mem[16] = 8'h93;
    init_mem[17] = 8'h00;
    init_mem[18] = 8'h10;
    init_mem[19] = 8'h00;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_mem[i];
    bt = '0;
    model_reset();

    mem_init   = 1'b1;
    rst        = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    load_req   = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    tick();
    tick();
    tick();
    mem_init = 1'b0;
    rst      = 1'b0;
    check_quiet("reset");

    // Directed vectors: known word, byte load then read-back, buffer reuse.
    do_fetch(6'h12);
    do_load(6'h05, 8'hAB);
    do_fetch(6'h04);
    do_fetch(6'h10);
    do_fetch(6'h10);
    do_load(6'h11, 8'h5A);
    do_fetch(6'h10);

    // Reset while the third byte (counter 2) is being read.
    sbq.push_back(model_fetch(6'h24));
    fetch_addr = 6'h24;
    fetch_req  = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      if (mem_read_rq && mem_addr == 6'h26) found = 1'b1;
    end
    if (!found) check("rd_cnt2_timeout", 32'h0, 32'h1);
    rst = 1'b1;
    model_reset();
    tick();
    rst       = 1'b0;
    fetch_req = 1'b0;
    check_quiet("abort");
    tick();
    check_quiet("abort_idle");
    do_fetch(6'h24);

    // Both requesters held from reset: load, fetch, load, fetch.
    rst = 1'b1;
    model_reset();
    fa[0] = 6'h30; fa[1] = 6'h18;
    la[0] = 6'h19; la[1] = 6'h31;
    ld[0] = 8'($urandom); ld[1] = 8'($urandom);
    sbq.push_back(model_load(la[0], ld[0]));
    sbq.push_back(model_fetch(fa[0]));
    sbq.push_back(model_load(la[1], ld[1]));
    sbq.push_back(model_fetch(fa[1]));
    fetch_addr = fa[0];
    fetch_req  = 1'b1;
    load_addr  = la[0];
    load_data  = ld[0];
    load_req   = 1'b1;
    tick();
    rst = 1'b0;
    fi = 0;
    li = 0;
    for (int n = 0; n < 60 && (fi < 2 || li < 2); n++) begin
      tick();
      if (load_ack) begin
        li++;
        if (li < 2) begin
          load_addr = la[li];
          load_data = ld[li];
        end else begin
          load_req = 1'b0;
        end
      end
      if (fetch_valid) begin
        fi++;
        if (fi < 2) fetch_addr = fa[fi];
        else fetch_req = 1'b0;
      end
    end
    check("contention_done", 32'(fi + li), 32'd4);
    fetch_req = 1'b0;
    load_req  = 1'b0;
    tick();

    // Random mix in a narrow window so buffer hits and invalidations occur.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 1) == 0) do_fetch(6'($urandom_range(16, 31)));
      else do_load(6'($urandom_range(16, 31)), 8'($urandom));
      idle = $urandom_range(0, 2);
      for (int j = 0; j < idle; j++) tick();
    end

    tick();
    check("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port fetch_req  in  1  CPU requests one 32-bit instruction word; held until fetch_valid.
REQ-004 SHALL have port fetch_addr  in  6  byte address; bits [1:0] ignored (word-aligned base = {fetch_addr[5:2],2'b00}).
REQ-005 SHALL have port fetch_valid  out  1  one-cycle pulse; fetch_data valid in that cycle.
REQ-006 SHALL have port fetch_data  out  32  assembled word, little-endian (byte at base+0 in [7:0]).
REQ-007 SHALL have port load_req  in  1  program loader requests one byte write; held until load_ack.
REQ-008 SHALL have ports load_addr  in  6 and load_data  in  8  loader byte address and data.
REQ-009 SHALL have port load_ack  out  1  one-cycle pulse in the cycle the byte write is driven to memory.
REQ-010 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-011 SHALL have ports mem_read_rq, mem_write_rq  out  1 each; mem_addr  out  6; mem_wdata  out  8; mem_rdata  in  8 (memory read is combinational, write commits at next edge).

Function
REQ-012 SHALL implement FSM states IDLE, RD (2-bit byte counter), WR, RESP.
REQ-013 In IDLE, SHALL accept at most one request per cycle; if only one of fetch_req/load_req is high it SHALL be granted.
REQ-014 If both requests are high in IDLE, SHALL grant the requester not granted last (round-robin flag, updated on each grant).
REQ-015 Fetch grant SHALL latch the word base and go to RD with counter 0.
REQ-016 In RD SHALL drive mem_read_rq=1, mem_write_rq=0, mem_addr=base+counter, capture mem_rdata into byte lane [counter] at the edge, increment counter; after counter 3 go to RESP.
REQ-017 In RESP SHALL assert fetch_valid=1 for exactly one cycle with complete fetch_data, then return to IDLE; fetch_valid therefore rises 5 cycles after the accepting edge (miss path).
REQ-018 Load grant SHALL latch load_addr/load_data and go to WR; in WR SHALL drive mem_write_rq=1, mem_read_rq=0, mem_addr/mem_wdata from latches, load_ack=1, then return to IDLE.
REQ-019 mem_read_rq and mem_write_rq SHALL never be high simultaneously; both SHALL be 0 in IDLE and RESP.
REQ-020 fetch_data SHALL hold its last value outside RESP; requests arriving while busy SHALL wait (no drop, no queue beyond the held request).
REQ-021 Address arithmetic SHALL be 6-bit; base+3 never exceeds 63, so no wrap occurs.

Reset
REQ-022 On rst high at an edge SHALL enter IDLE, clear counter, set round-robin flag so load wins the first tie, clear fetch_data to 0, clear word-buffer valid.
REQ-023 Reset mid-RD or mid-WR SHALL abort the operation with no fetch_valid/load_ack; all outputs are 0 from the following cycle.

Configuration
REQ-024 Macro IMEM_FETCH_HIT_EN defined: SHALL keep a one-entry word buffer (tag = base[5:2], valid bit); a fetch hitting a valid tag SHALL go IDLE->RESP directly (fetch_valid one cycle after accept) without memory reads; a completed miss fills the buffer; a WR whose load_addr[5:2] equals the tag SHALL clear valid.
REQ-025 Macro undefined: SHALL contain no buffer; every fetch uses the full RD sequence.

Structure
REQ-026 Package imem_ctrl_pkg SHALL hold the state enum, ADDR_W=6, BYTE_W=8, WORD_BYTES=4.
REQ-027 The word buffer SHALL be sub-module imem_word_buf (tag, valid, data, fill, invalidate), instantiated only under IMEM_FETCH_HIT_EN.

Verification
REQ-028 Memory bytes 0x10..0x13 = 0x93,0x00,0x10,0x00; fetch_addr=0x12 -> mem_addr 0x10..0x13 on 4 cycles, fetch_valid 5 cycles after accept, fetch_data=0x00100093.
REQ-029 load_req addr=0x05 data=0xAB -> one WR cycle, load_ack=1, mem_write_rq=1, mem_addr=0x05; subsequent fetch 0x04 returns byte1=0xAB.
REQ-030 fetch_req and load_req high together from reset, held -> load granted first, then fetch, then alternating on continued contention.
REQ-031 rst pulsed during RD counter 2 -> no fetch_valid, busy=0 and strobes 0 next cycle, re-issued fetch completes normally.
REQ-032 With IMEM_FETCH_HIT_EN: repeat fetch 0x10 -> fetch_valid one cycle after accept, no mem_read_rq; load to 0x11 then fetch 0x10 -> full 4-read miss with updated data.
